// File: rtl/bomb_scheduler_if.sv
// Bomb scheduler request/result bus: player placement requests in,
// ack/nack pulses, per-cell code planes and live-slot count out.
interface bomb_scheduler_if;
  logic [1:0]  game_over;
  logic        p1_place_req;
  logic [6:0]  p1_cell;
  logic        p2_place_req;
  logic [6:0]  p2_cell;
  logic        p1_ack;
  logic        p1_nack;
  logic        p2_ack;
  logic        p2_nack;
  logic [99:0] Bomb_bit0;
  logic [99:0] Bomb_bit1;
  logic [3:0]  active_count;

  modport master (
    output game_over, p1_place_req, p1_cell,
    output p2_place_req, p2_cell,
    input  p1_ack, p1_nack, p2_ack, p2_nack,
    input  Bomb_bit0, Bomb_bit1, active_count
  );

  modport slave (
    input  game_over, p1_place_req, p1_cell,
    input  p2_place_req, p2_cell,
    output p1_ack, p1_nack, p2_ack, p2_nack,
    output Bomb_bit0, Bomb_bit1, active_count
  );
endinterface

// File: rtl/bomb_scheduler.sv
// Bomb slot pool, placement arbitration, fuse timing and 10x10 code planes.
// Optional BOMB_SCHED_CHAIN_EN: blasts detonate armed/fusing bombs they cover.
module bomb_scheduler #(
  parameter int NUM_SLOTS   = 4,
  parameter int PER_PLAYER  = 2,
  parameter int TICK_DIV    = 25000000,
  parameter int ARM_TICKS   = 1,
  parameter int FUSE_TICKS  = 1,
  parameter int BLAST_TICKS = 1
) (
  input logic pixel_clk,
  input logic rst,
  bomb_scheduler_if.slave bus
);
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NEW  = 2'd1;
  localparam logic [1:0] S_FUSE = 2'd2;
  localparam logic [1:0] S_EXPL = 2'd3;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0] st_q [NUM_SLOTS];
  logic [1:0] st_d [NUM_SLOTS];
  logic [7:0] cnt_q [NUM_SLOTS];
  logic [7:0] cnt_d [NUM_SLOTS];
  logic [6:0] cell_q [NUM_SLOTS];
  logic [6:0] cell_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] own_q, own_d;
  logic rr_q, rr_d;
  logic ack1_q, nack1_q, ack2_q, nack2_q;
  logic ack1_d, nack1_d, ack2_d, nack2_d;
  logic [99:0] b0_q, b1_q, b0_d, b1_d;
  logic [3:0] act_q, act_d;

  logic frozen, tick;
  logic has1, has2, busy1, busy2;
  logic [SW-1:0] f1, f2, p2slot;
  logic [3:0] own1, own2;
  logic ok1, ok2, both, joint, g1, g2;
  logic [99:0] ex_d, n1_d, n2_d, fp_d;
`ifdef BOMB_SCHED_CHAIN_EN
  logic [99:0] ex_q, fp_q;
`endif

  assign frozen = |bus.game_over;
  assign tick = !frozen && (presc_q == PW'(TICK_DIV - 1));
  assign presc_d = frozen ? presc_q : (tick ? '0 : presc_q + 1'b1);

  always_comb begin
    has1 = 1'b0;
    has2 = 1'b0;
    f1 = '0;
    f2 = '0;
    own1 = '0;
    own2 = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (st_q[s] == S_IDLE) begin
        if (!has1) begin
          has1 = 1'b1;
          f1 = SW'(s);
        end else if (!has2) begin
          has2 = 1'b1;
          f2 = SW'(s);
        end
      end else begin
        if (own_q[s]) own2 = own2 + 4'd1;
        else own1 = own1 + 4'd1;
        if (cell_q[s] == bus.p1_cell) busy1 = 1'b1;
        if (cell_q[s] == bus.p2_cell) busy2 = 1'b1;
      end
    end
  end

  assign ok1 = bus.p1_place_req && !frozen && (bus.p1_cell <= 7'd99)
            && !busy1 && (own1 < 4'(PER_PLAYER)) && has1;
  assign ok2 = bus.p2_place_req && !frozen && (bus.p2_cell <= 7'd99)
            && !busy2 && (own2 < 4'(PER_PLAYER)) && has1;
  assign both = ok1 && ok2;
  assign joint = both && (bus.p1_cell != bus.p2_cell) && has2;
  // Contested only when both are individually grantable but not jointly
  assign g1 = ok1 && (!both || joint || !rr_q);
  assign g2 = ok2 && (!both || joint || rr_q);
  assign rr_d = (both && !joint) ? !rr_q : rr_q;
  assign p2slot = (g1 && g2) ? f2 : f1;

  assign ack1_d = g1;
  assign nack1_d = bus.p1_place_req && !g1;
  assign ack2_d = g2;
  assign nack2_d = bus.p2_place_req && !g2;

  always_comb begin
    own_d = own_q;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      st_d[s] = st_q[s];
      cnt_d[s] = cnt_q[s];
      cell_d[s] = cell_q[s];
      if (st_q[s] != S_IDLE && tick) begin
        if (cnt_q[s] > 8'd1) begin
          cnt_d[s] = cnt_q[s] - 8'd1;
        end else begin
          unique case (1'b1)
            st_q[s] == S_NEW: begin
              st_d[s] = S_FUSE;
              cnt_d[s] = 8'(FUSE_TICKS);
            end
            st_q[s] == S_FUSE: begin
              st_d[s] = S_EXPL;
              cnt_d[s] = 8'(BLAST_TICKS);
            end
            default: begin
              st_d[s] = S_IDLE;
              cnt_d[s] = '0;
            end
          endcase
        end
      end
`ifdef BOMB_SCHED_CHAIN_EN
      if ((st_q[s] == S_NEW || st_q[s] == S_FUSE) && fp_q[cell_q[s]]) begin
        st_d[s] = S_EXPL;
        cnt_d[s] = 8'(BLAST_TICKS);
      end
`endif
      if (g1 && f1 == SW'(s)) begin
        st_d[s] = S_NEW;
        cnt_d[s] = 8'(ARM_TICKS);
        cell_d[s] = bus.p1_cell;
        own_d[s] = 1'b0;
      end
      if (g2 && p2slot == SW'(s)) begin
        st_d[s] = S_NEW;
        cnt_d[s] = 8'(ARM_TICKS);
        cell_d[s] = bus.p2_cell;
        own_d[s] = 1'b1;
      end
    end
  end

  always_comb begin
    ex_d = '0;
    n1_d = '0;
    n2_d = '0;
    act_d = '0;
`ifdef BOMB_SCHED_CHAIN_EN
    ex_q = '0;
`endif
    for (int s = 0; s < NUM_SLOTS; s++) begin
      case (st_d[s])
        S_NEW:   n1_d[cell_d[s]] = 1'b1;
        S_FUSE:  n2_d[cell_d[s]] = 1'b1;
        S_EXPL:  ex_d[cell_d[s]] = 1'b1;
        default: ;
      endcase
      if (st_d[s] != S_IDLE) act_d = act_d + 4'd1;
`ifdef BOMB_SCHED_CHAIN_EN
      if (st_q[s] == S_EXPL) ex_q[cell_q[s]] = 1'b1;
`endif
    end
  end

  // Edge cells reuse their own index for a clipped neighbour
  for (genvar k = 0; k < 100; k++) begin : g_fp
    localparam int KW = (k % 10 != 0) ? k - 1 : k;
    localparam int KE = (k % 10 != 9) ? k + 1 : k;
    localparam int KN = (k >= 10) ? k - 10 : k;
    localparam int KS = (k < 90) ? k + 10 : k;
    assign fp_d[k] = ex_d[k] | ex_d[KW] | ex_d[KE] | ex_d[KN] | ex_d[KS];
`ifdef BOMB_SCHED_CHAIN_EN
    assign fp_q[k] = ex_q[k] | ex_q[KW] | ex_q[KE] | ex_q[KN] | ex_q[KS];
`endif
  end

  assign b1_d = n2_d | fp_d;
  assign b0_d = (n1_d & ~n2_d) | fp_d;

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      presc_q <= '0;
      rr_q <= 1'b0;
      own_q <= '0;
      ack1_q <= 1'b0;
      nack1_q <= 1'b0;
      ack2_q <= 1'b0;
      nack2_q <= 1'b0;
      b0_q <= '0;
      b1_q <= '0;
      act_q <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        st_q[s] <= S_IDLE;
        cnt_q[s] <= '0;
        cell_q[s] <= '0;
      end
    end else begin
      presc_q <= presc_d;
      rr_q <= rr_d;
      own_q <= own_d;
      ack1_q <= ack1_d;
      nack1_q <= nack1_d;
      ack2_q <= ack2_d;
      nack2_q <= nack2_d;
      b0_q <= b0_d;
      b1_q <= b1_d;
      act_q <= act_d;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        st_q[s] <= st_d[s];
        cnt_q[s] <= cnt_d[s];
        cell_q[s] <= cell_d[s];
      end
    end
  end

  assign bus.p1_ack = ack1_q;
  assign bus.p1_nack = nack1_q;
  assign bus.p2_ack = ack2_q;
  assign bus.p2_nack = nack2_q;
  assign bus.Bomb_bit0 = b0_q;
  assign bus.Bomb_bit1 = b1_q;
  assign bus.active_count = act_q;
endmodule

// File: tb/tb_bomb_scheduler.sv
// Directed bench for bomb_scheduler with TICK_DIV=4: arbitration table
// plus hand sequences for fuse timing, clipping, freeze, reset and chaining.
module tb_bomb_scheduler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bomb_scheduler_if bus ();

  bomb_scheduler #(
    .NUM_SLOTS(4),
    .PER_PLAYER(2),
    .TICK_DIV(4),
    .ARM_TICKS(1),
    .FUSE_TICKS(1),
    .BLAST_TICKS(1)
  ) dut (
    .pixel_clk(clk),
    .rst(rst),
    .bus(bus)
  );

`ifdef BOMB_SCHED_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  typedef struct {
    logic       r1;
    logic [6:0] c1;
    logic       r2;
    logic [6:0] c2;
    logic       go;
    logic [3:0] res;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl [17];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic r1, input int c1, input logic r2,
                              input int c2, input logic go,
                              input logic [3:0] res, input int cnt);
    vec_t v;
    v.r1 = r1;
    v.c1 = 7'(c1);
    v.r2 = r2;
    v.c2 = 7'(c2);
    v.go = go;
    v.res = res;
    v.cnt = 4'(cnt);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [31:0] code(input int k);
    return {30'd0, bus.Bomb_bit1[k], bus.Bomb_bit0[k]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic clr_req();
    bus.p1_place_req = 1'b0;
    bus.p2_place_req = 1'b0;
  endtask

  task automatic do_reset();
    clr_req();
    bus.game_over = 2'd0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic req(input bit p2, input int c);
    if (p2) begin
      bus.p2_place_req = 1'b1;
      bus.p2_cell = 7'(c);
    end else begin
      bus.p1_place_req = 1'b1;
      bus.p1_cell = 7'(c);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.game_over = 2'd0;
    bus.p1_place_req = 1'b0;
    bus.p2_place_req = 1'b0;
    bus.p1_cell = '0;
    bus.p2_cell = '0;

    // {a1,n1,a2,n2}; row i is sampled at edge R+1+i
    tbl[0]  = mk(1, 23, 1, 23, 0, 4'b1001, 1);
    tbl[1]  = mk(1, 55, 1, 55, 0, 4'b0110, 2);
    tbl[2]  = mk(1, 23, 1, 120, 0, 4'b0101, 2);
    tbl[3]  = mk(1, 10, 1, 11, 0, 4'b1010, 4);
    tbl[4]  = mk(1, 30, 1, 31, 0, 4'b0101, 4);
    for (int i = 5; i <= 10; i++) tbl[i] = mk(0, 0, 0, 0, 0, 4'b0000, 4);
    tbl[11] = mk(1, 40, 0, 0, 0, 4'b0100, 2);
    tbl[12] = mk(1, 40, 0, 0, 0, 4'b1000, 3);
    tbl[13] = mk(0, 0, 1, 40, 0, 4'b0001, 3);
    tbl[14] = mk(0, 0, 1, 70, 1, 4'b0001, 3);
    tbl[15] = mk(0, 0, 1, 70, 0, 4'b0010, 4);
    tbl[16] = mk(0, 0, 0, 0, 0, 4'b0000, 2);

    do_reset();
    chk("rst_planes", 32'(|(bus.Bomb_bit0 | bus.Bomb_bit1)), 0);
    chk("rst_count", 32'(bus.active_count), 0);
    chk("rst_acks", 32'({bus.p1_ack, bus.p1_nack, bus.p2_ack, bus.p2_nack}), 0);

    for (int i = 0; i < 17; i++) begin
      bus.p1_place_req = tbl[i].r1;
      bus.p1_cell = tbl[i].c1;
      bus.p2_place_req = tbl[i].r2;
      bus.p2_cell = tbl[i].c2;
      bus.game_over = {1'b0, tbl[i].go};
      step();
      clr_req();
      bus.game_over = 2'd0;
      chk($sformatf("tbl%0d_res", i),
          32'({bus.p1_ack, bus.p1_nack, bus.p2_ack, bus.p2_nack}),
          32'(tbl[i].res));
      chk($sformatf("tbl%0d_cnt", i), 32'(bus.active_count), 32'(tbl[i].cnt));
    end

    // Full lifecycle of one bomb granted on a tick edge
    do_reset();
    idle(3);
    req(0, 23);
    step();
    clr_req();
    chk("life_ack", 32'(bus.p1_ack), 1);
    chk("life_new", code(23), 1);
    chk("life_cnt1", 32'(bus.active_count), 1);
    idle(3);
    chk("life_new_hold", code(23), 1);
    step();
    chk("life_fuse", code(23), 2);
    idle(4);
    chk("life_expl", code(23), 3);
    chk("life_n13", code(13), 3);
    chk("life_n22", code(22), 3);
    chk("life_n24", code(24), 3);
    chk("life_n33", code(33), 3);
    chk("life_diag12", code(12), 0);
    idle(4);
    chk("life_free", code(23), 0);
    chk("life_free_n33", code(33), 0);
    chk("life_cnt0", 32'(bus.active_count), 0);

    // Edge clipping and per-player limit
    do_reset();
    idle(3);
    req(0, 9);
    step();
    req(0, 90);
    step();
    req(0, 50);
    step();
    clr_req();
    chk("lim_nack", 32'(bus.p1_nack), 1);
    idle(9);
    chk("clip_9", code(9), 3);
    chk("clip_8", code(8), 3);
    chk("clip_19", code(19), 3);
    chk("clip_10", code(10), 0);
    chk("clip_0", code(0), 0);
    chk("clip_89", code(89), 0);
    chk("clip_91", code(91), 3);
    chk("clip_80", code(80), 3);

    // Freeze while fusing: codes hold, requests nacked, prescaler holds
    do_reset();
    idle(3);
    req(0, 23);
    step();
    clr_req();
    idle(4);
    chk("frz_fuse", code(23), 2);
    bus.game_over = 2'b10;
    req(1, 60);
    step();
    clr_req();
    chk("frz_nack", 32'({bus.p2_ack, bus.p2_nack}), 1);
    idle(7);
    chk("frz_hold", code(23), 2);
    bus.game_over = 2'd0;
    idle(3);
    chk("frz_resume", code(23), 2);
    step();
    chk("frz_expl", code(23), 3);

    // Reset with bombs live
    do_reset();
    req(0, 23);
    step();
    req(1, 60);
    step();
    clr_req();
    chk("mid_cnt", 32'(bus.active_count), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_planes", 32'(|(bus.Bomb_bit0 | bus.Bomb_bit1)), 0);
    chk("mid_cnt0", 32'(bus.active_count), 0);
    req(0, 23);
    step();
    clr_req();
    chk("mid_reack", 32'(bus.p1_ack), 1);
    chk("mid_code", code(23), 1);

    // Adjacent bombs one tick apart
    do_reset();
    idle(3);
    req(0, 44);
    step();
    clr_req();
    idle(3);
    req(1, 45);
    step();
    clr_req();
    idle(4);
    chk("ch_44", code(44), 3);
    chk("ch_45", code(45), 3);
    chk("ch_46_pre", code(46), 0);
    step();
    chk("ch_46", code(46), CHAIN ? 3 : 0);
    idle(3);
    chk("ch_45_late", code(45), CHAIN ? 0 : 3);
    idle(4);
    chk("ch_45_end", code(45), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
